// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with valid/ready handshakes
//
// Purpose:
//   Adds two WIDTH-bit operands LSB-first through one full-adder cell and a
//   registered carry, one bit per clock. Operands are accepted over an
//   in_valid/in_ready handshake and the result is offered over an
//   out_valid/out_ready handshake. Optional subtraction is enabled by
//   defining the macro SERIAL_ADDER_SUB_EN, which adds the sub input.
//
// Parameters:
//   WIDTH     - operand/sum width in bits (1..32)
//   INVERT_IN - 1: a, b, cin are active-low pins, inverted at capture
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands present
//   in_ready  - block can accept operands (high only in IDLE)
//   a, b      - operands
//   cin       - carry-in
//   sub       - (SERIAL_ADDER_SUB_EN only) compute a - b, active-high
//   out_valid - result available (DONE)
//   out_ready - consumer accepts result
//   sum       - result bits
//   cout      - carry out of MSB (for subtraction: 1 = no borrow)
//   ovf       - signed overflow
//   busy      - state is not IDLE

module serial_adder #(
    parameter int WIDTH     = 4,
    parameter bit INVERT_IN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, b_sr_q, res_sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q, ovf_q;

    // Capture-side operand conditioning
    logic [WIDTH-1:0]   a_pin, b_pin, b_cap;
    logic               cin_pin, c_cap;

    assign a_pin   = INVERT_IN ? ~a   : a;
    assign b_pin   = INVERT_IN ? ~b   : b;
    assign cin_pin = INVERT_IN ? ~cin : cin;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b = a + ~b + 1; cin is ignored while subtracting
    assign b_cap = sub ? ~b_pin : b_pin;
    assign c_cap = sub ? 1'b1   : cin_pin;
`else
    assign b_cap = b_pin;
    assign c_cap = cin_pin;
`endif

    // Single full-adder cell
    logic s_bit, c_next;
    logic [WIDTH-1:0] res_next;
    logic last_bit;

    assign s_bit    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign c_next   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB-first
    // bits sit in their natural positions.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = s_bit;
        end else begin : g_res_wn
            assign res_next = {s_bit, res_sr_q[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr_q  <= a_pin;
                        b_sr_q  <= b_cap;
                        carry_q <= c_cap;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    carry_q  <= c_next;
                    res_sr_q <= res_next;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB
                        sum_q  <= res_next;
                        cout_q <= c_next;
                        ovf_q  <= c_next ^ carry_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
